axi_write_arbiter: RTL and testbench
====================================

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 SHALL have no parameters; address and data widths are fixed at 32 bits and strobe at 4 bits.
REQ-002 SHALL have one clock and an asynchronous active-low reset (ports listed below).
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 awaddrA/awaddrB  input  32  master A/B write address.
REQ-006 awvalidA/awvalidB  input  1 / awreadyA/awreadyB  output  1  master A/B AW handshake.
REQ-007 wdataA/wdataB  input  32 / wstrbA/wstrbB  input  4  master A/B write data and byte strobe.
REQ-008 wvalidA/wvalidB  input  1 / wreadyA/wreadyB  output  1  master A/B W handshake.
REQ-009 bvalidA/bvalidB  output  1 / brespA/brespB  output  2 / breadyA/breadyB  input  1  master A/B B channel.
REQ-010 awaddr  output  32 / awvalid  output  1 / awready  input  1  downstream AW channel.
REQ-011 wdata  output  32 / wstrb  output  4 / wvalid  output  1 / wready  input  1  downstream W channel.
REQ-012 bvalid  input  1 / bresp  input  2 / bready  output  1  downstream B channel.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, RESP; one write outstanding at most.
REQ-014 IDLE: a master requests only when its awvalid AND wvalid are both high; AW-only or W-only is ignored.
REQ-015 IDLE grant: fixed priority A over B (see REQ-026 for round-robin); grant is combinational in the same cycle.
REQ-016 IDLE with a grant: SHALL assert awready and wready of the granted master only, for that single cycle; capture awaddr/wdata/wstrb; record grant; next state SEND.
REQ-017 SEND: awvalid and wvalid SHALL be registered, both 1 on entry, driving captured values held stable.
REQ-018 SEND: awvalid drops the cycle after awready&&awvalid; wvalid drops the cycle after wready&&wvalid; both may complete in the same cycle; W may complete before AW.
REQ-019 SEND -> RESP when both AW and W have completed; no new upstream acceptance during SEND or RESP.
REQ-020 RESP: bready = granted master's bready; granted bvalid = bvalid and bresp = bresp combinationally (zero latency).
REQ-021 RESP -> IDLE on bvalid&&bready; a new grant is possible in the following cycle, not the same one.
REQ-022 Non-granted master, and both masters outside their grant: awready=wready=bvalid=0, bresp=2'b00.
REQ-023 Downstream bvalid in IDLE or SEND SHALL be ignored (bready=0).
REQ-024 Minimum transaction: 1 cycle accept + 1 cycle SEND + 1 cycle RESP with zero-wait downstream.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, awvalid=wvalid=bready=0, all upstream readies/bvalids 0, captured registers 0, last-grant = B; any in-flight write is dropped without response.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined: when both masters request in IDLE, grant the master not granted last (after reset A wins); last-grant updates on RESP completion. Without it: fixed A priority, last-grant register omitted.

Structure
REQ-027 Shared package axi_pkg SHALL hold resp codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the FSM state enum.
REQ-028 Grant selection SHALL live in one sub-module wr_grant_sel (requests, last-grant in; one-hot grant out).

Verification
REQ-029 A: awaddr=0x8000_0010, wdata=0xDEAD_BEEF, wstrb=4'hF, downstream ready 1, bresp=00 -> downstream sees same values 1 cycle after accept; bvalidA=1 with brespA=00; B sees nothing.
REQ-030 A and B request same cycle, fixed priority -> A granted, B stalls with awreadyB=0 until A's B handshake, then B granted next cycle; with ARB_ROUND_ROBIN_EN, back-to-back A,B repeats alternate A,B,A,B.
REQ-031 Downstream wready in cycle 1, awready in cycle 4 -> wvalid low from cycle 2, awvalid held until cycle 4 handshake, RESP entered after.
REQ-032 B requests with awvalidB=1, wvalidB=0 -> no grant; raise wvalidB -> grant same cycle.
REQ-033 Downstream bresp=2'b10 with breadyB=0 for 3 cycles -> bvalidB=1, brespB=10 held, state RESP until breadyB=1.
REQ-034 rst_n low during SEND -> awvalid/wvalid drop immediately; after release, new A write completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared definitions for the two-master AXI write arbiter: response codes,
// FSM state encoding and one-hot grant constants.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

endpackage

// File: rtl/wr_grant_sel.sv
// Combinational grant selection between masters A and B (one-hot out).
// On a tie the master not granted last wins; tying last_b high gives fixed A priority.
module wr_grant_sel
  import axi_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_b,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (req_a && req_b) begin
      gnt = last_b ? GNT_A : GNT_B;
    end else if (req_a) begin
      gnt = GNT_A;
    end else if (req_b) begin
      gnt = GNT_B;
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Two-master AXI write arbiter, one write outstanding (IDLE -> SEND -> RESP).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed A priority.
//
// state   | meaning
// IDLE    | waiting for a master with both AW and W valid; accepts in one cycle
// SEND    | driving captured AW/W downstream until both handshakes complete
// RESP    | forwarding downstream B channel to the granted master
module axi_write_arbiter
  import axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] awaddrA,
  input  logic        awvalidA,
  output logic        awreadyA,
  input  logic [31:0] wdataA,
  input  logic [3:0]  wstrbA,
  input  logic        wvalidA,
  output logic        wreadyA,
  output logic        bvalidA,
  output logic [1:0]  brespA,
  input  logic        breadyA,
  input  logic [31:0] awaddrB,
  input  logic        awvalidB,
  output logic        awreadyB,
  input  logic [31:0] wdataB,
  input  logic [3:0]  wstrbB,
  input  logic        wvalidB,
  output logic        wreadyB,
  output logic        bvalidB,
  output logic [1:0]  brespB,
  input  logic        breadyB,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  input  logic [1:0]  bresp,
  output logic        bready
);

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  gnt_sel;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        req_a, req_b;
  logic        last_b;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_b_q, last_b_d;
  assign last_b = last_b_q;
`else
  assign last_b = 1'b1;
`endif

  // Reset gates requests so no upstream ready can pulse while rst_n is low.
  assign req_a = rst_n && awvalidA && wvalidA;
  assign req_b = rst_n && awvalidB && wvalidB;

  wr_grant_sel u_grant_sel (
    .req_a  (req_a),
    .req_b  (req_b),
    .last_b (last_b),
    .gnt    (gnt_sel)
  );

  assign awaddr  = addr_q;
  assign wdata   = data_q;
  assign wstrb   = strb_q;
  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_b_d  = last_b_q;
`endif
    awreadyA  = 1'b0;
    wreadyA   = 1'b0;
    bvalidA   = 1'b0;
    brespA    = RESP_OKAY;
    awreadyB  = 1'b0;
    wreadyB   = 1'b0;
    bvalidB   = 1'b0;
    brespB    = RESP_OKAY;
    bready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_sel != GNT_NONE) begin
          awreadyA  = gnt_sel[0];
          wreadyA   = gnt_sel[0];
          awreadyB  = gnt_sel[1];
          wreadyB   = gnt_sel[1];
          gnt_d     = gnt_sel;
          addr_d    = gnt_sel[0] ? awaddrA : awaddrB;
          data_d    = gnt_sel[0] ? wdataA  : wdataB;
          strb_d    = gnt_sel[0] ? wstrbA  : wstrbB;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = ST_RESP;
      end

      ST_RESP: begin
        bready  = gnt_q[0] ? breadyA : breadyB;
        bvalidA = gnt_q[0] && bvalid;
        bvalidB = gnt_q[1] && bvalid;
        brespA  = gnt_q[0] ? bresp : RESP_OKAY;
        brespB  = gnt_q[1] ? bresp : RESP_OKAY;
        if (bvalid && bready) begin
          state_d = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          last_b_d = gnt_q[1];
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= GNT_NONE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_b_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_b_q  <= last_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: expected downstream writes are queued
// at grant time and compared when the DUT drives them; grant order comes from a local model.
module tb_axi_write_arbiter;
  import axi_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] awaddrA, wdataA, awaddrB, wdataB;
  logic [3:0]  wstrbA, wstrbB;
  logic        awvalidA, wvalidA, breadyA, awvalidB, wvalidB, breadyB;
  logic        awreadyA, wreadyA, bvalidA, awreadyB, wreadyB, bvalidB;
  logic [1:0]  brespA, brespB;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  bresp;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   tb_last_b = 1'b1;

  axi_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .awaddrA(awaddrA), .awvalidA(awvalidA), .awreadyA(awreadyA),
    .wdataA(wdataA), .wstrbA(wstrbA), .wvalidA(wvalidA), .wreadyA(wreadyA),
    .bvalidA(bvalidA), .brespA(brespA), .breadyA(breadyA),
    .awaddrB(awaddrB), .awvalidB(awvalidB), .awreadyB(awreadyB),
    .wdataB(wdataB), .wstrbB(wstrbB), .wvalidB(wvalidB), .wreadyB(wreadyB),
    .bvalidB(bvalidB), .brespB(brespB), .breadyB(breadyB),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  function automatic logic [1:0] model_grant(bit ra, bit rb);
    if (ra && rb) begin
`ifdef ARB_ROUND_ROBIN_EN
      return tb_last_b ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    if (ra) return 2'b01;
    if (rb) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(bit v, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    awvalidA = v; wvalidA = v; awaddrA = a; wdataA = d; wstrbA = s;
  endtask

  task automatic set_b(bit v, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    awvalidB = v; wvalidB = v; awaddrB = a; wdataB = d; wstrbB = s;
  endtask

  task automatic push_grant(logic [1:0] g);
    txn_t t;
    t.addr = g[0] ? awaddrA : awaddrB;
    t.data = g[0] ? wdataA  : wdataB;
    t.strb = g[0] ? wstrbA  : wstrbB;
    exp_q.push_back(t);
  endtask

  // Drives a downstream response and waits (bounded) for the B handshake.
  task automatic finish_resp(input logic [1:0] r, output bit timed_out);
    bit hs;
    timed_out = 1'b1;
    bvalid = 1'b1;
    bresp  = r;
    for (int i = 0; i < 20; i++) begin
      #1;
      hs = (bready === 1'b1);
      step();
      if (hs) begin
        timed_out = 1'b0;
        break;
      end
    end
    bvalid = 1'b0;
    bresp  = RESP_OKAY;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_a(1'b1, 32'h1111_2222, 32'h3333_4444, 4'hF);
    set_b(1'b0, 32'h0, 32'h0, 4'h0);
    breadyA = 1'b1; breadyB = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = RESP_SLVERR;
    step();
    #1;
    total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL reset_awvalid: got %b want 0", awvalid); end
    total++; if (wvalid !== 1'b0) begin bad++; $display("FAIL reset_wvalid: got %b want 0", wvalid); end
    total++; if (bready !== 1'b0) begin bad++; $display("FAIL reset_bready: got %b want 0", bready); end
    total++; if ({awreadyA, wreadyA, bvalidA} !== 3'b000) begin bad++; $display("FAIL reset_upstream_a: got %b want 000", {awreadyA, wreadyA, bvalidA}); end
    total++; if (awaddr !== 32'h0) begin bad++; $display("FAIL reset_awaddr: got %h want 0", awaddr); end
    step();
    total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL reset_no_accept: got %b want 0", awvalid); end
    set_a(1'b0, 32'h0, 32'h0, 4'h0);
    bvalid = 1'b0; bresp = RESP_OKAY;
    rst_n = 1'b1;
    tb_last_b = 1'b1;
    step();
  endtask

  task automatic test_single_a();
    logic [1:0] g;
    txn_t t;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    set_a(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    g = model_grant(1'b1, 1'b0);
    #1;
    total++; if ({awreadyB, awreadyA} !== g) begin bad++; $display("FAIL single_awready: got %b want %b", {awreadyB, awreadyA}, g); end
    total++; if ({wreadyB, wreadyA} !== g) begin bad++; $display("FAIL single_wready: got %b want %b", {wreadyB, wreadyA}, g); end
    push_grant(g);
    step();
    set_a(1'b0, 32'h0, 32'h0, 4'h0);
    bvalid = 1'b1; bresp = RESP_OKAY;
    #1;
    t = exp_q.pop_front();
    total++; if ({awvalid, wvalid} !== 2'b11) begin bad++; $display("FAIL single_valids: got %b want 11", {awvalid, wvalid}); end
    total++; if (awaddr !== t.addr) begin bad++; $display("FAIL single_awaddr: got %h want %h", awaddr, t.addr); end
    total++; if (wdata !== t.data) begin bad++; $display("FAIL single_wdata: got %h want %h", wdata, t.data); end
    total++; if (wstrb !== t.strb) begin bad++; $display("FAIL single_wstrb: got %h want %h", wstrb, t.strb); end
    total++; if ({bready, bvalidA} !== 2'b00) begin bad++; $display("FAIL single_b_ignored_in_send: got %b want 00", {bready, bvalidA}); end
    step();
    #1;
    total++; if ({bvalidA, brespA} !== {1'b1, RESP_OKAY}) begin bad++; $display("FAIL single_bvalidA: got %b/%b want 1/00", bvalidA, brespA); end
    total++; if ({bvalidB, awvalid} !== 2'b00) begin bad++; $display("FAIL single_b_quiet: got %b want 00", {bvalidB, awvalid}); end
    step();
    bvalid = 1'b0;
    tb_last_b = 1'b0;
    #1;
    total++; if (bvalidA !== 1'b0) begin bad++; $display("FAIL single_done: got %b want 0", bvalidA); end
  endtask

  task automatic test_priority();
    logic [1:0] g1, g2;
    txn_t t;
    bit to;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    set_a(1'b1, 32'hA000_0100, 32'hA5A5_0001, 4'h3);
    set_b(1'b1, 32'hB000_0200, 32'hB5B5_0002, 4'hC);
    g1 = model_grant(1'b1, 1'b1);
    #1;
    total++; if ({awreadyB, awreadyA} !== g1) begin bad++; $display("FAIL prio_first_grant: got %b want %b", {awreadyB, awreadyA}, g1); end
    push_grant(g1);
    step();
    if (g1[0]) set_a(1'b0, awaddrA, wdataA, wstrbA);
    else       set_b(1'b0, awaddrB, wdataB, wstrbB);
    #1;
    t = exp_q.pop_front();
    total++; if (awaddr !== t.addr) begin bad++; $display("FAIL prio_first_addr: got %h want %h", awaddr, t.addr); end
    total++; if ({awreadyB, awreadyA} !== 2'b00) begin bad++; $display("FAIL prio_stall_send: got %b want 00", {awreadyB, awreadyA}); end
    step();
    #1;
    total++; if ({awreadyB, awreadyA, bvalidB, bvalidA} !== 4'b0000) begin bad++; $display("FAIL prio_stall_resp: got %b want 0000", {awreadyB, awreadyA, bvalidB, bvalidA}); end
    step();
    bvalid = 1'b1;
    #1;
    total++; if ({bvalidB, bvalidA} !== g1) begin bad++; $display("FAIL prio_first_bvalid: got %b want %b", {bvalidB, bvalidA}, g1); end
    total++; if ({awreadyB, awreadyA} !== 2'b00) begin bad++; $display("FAIL prio_no_same_cycle_grant: got %b want 00", {awreadyB, awreadyA}); end
    step();
    bvalid = 1'b0;
    tb_last_b = g1[1];
    g2 = model_grant(awvalidA && wvalidA, awvalidB && wvalidB);
    #1;
    total++; if ({awreadyB, awreadyA} !== g2) begin bad++; $display("FAIL prio_second_grant: got %b want %b", {awreadyB, awreadyA}, g2); end
    push_grant(g2);
    step();
    set_a(1'b0, 32'h0, 32'h0, 4'h0);
    set_b(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    t = exp_q.pop_front();
    total++; if ({awaddr, wdata} !== {t.addr, t.data}) begin bad++; $display("FAIL prio_second_payload: got %h/%h want %h/%h", awaddr, wdata, t.addr, t.data); end
    finish_resp(RESP_OKAY, to);
    total++; if (to) begin bad++; $display("FAIL prio_second_resp: got timeout want handshake"); end
    tb_last_b = g2[1];
  endtask

  task automatic test_b_partial_slverr();
    logic [1:0] g;
    txn_t t;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    set_b(1'b0, 32'h0C00_0040, 32'h0BAD_F00D, 4'h6);
    awvalidB = 1'b1;
    #1;
    total++; if ({awreadyB, wreadyB} !== 2'b00) begin bad++; $display("FAIL partial_aw_only: got %b want 00", {awreadyB, wreadyB}); end
    step();
    #1;
    total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL partial_not_accepted: got %b want 0", awvalid); end
    wvalidB = 1'b1;
    g = model_grant(1'b0, 1'b1);
    #1;
    total++; if ({awreadyB, awreadyA, wreadyB, wreadyA} !== {g, g}) begin bad++; $display("FAIL partial_grant: got %b want %b", {awreadyB, awreadyA, wreadyB, wreadyA}, {g, g}); end
    push_grant(g);
    step();
    set_b(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    t = exp_q.pop_front();
    total++; if ({awaddr, wstrb} !== {t.addr, t.strb}) begin bad++; $display("FAIL partial_payload: got %h/%h want %h/%h", awaddr, wstrb, t.addr, t.strb); end
    step();
    bvalid = 1'b1; bresp = RESP_SLVERR; breadyB = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({bvalidB, brespB, bready} !== {1'b1, RESP_SLVERR, 1'b0}) begin bad++; $display("FAIL hold_slverr_%0d: got %b/%b/%b want 1/10/0", i, bvalidB, brespB, bready); end
      step();
    end
    breadyB = 1'b1;
    #1;
    total++; if (bready !== 1'b1) begin bad++; $display("FAIL hold_release: got %b want 1", bready); end
    step();
    bvalid = 1'b0; bresp = RESP_OKAY;
    tb_last_b = 1'b1;
    #1;
    total++; if (bvalidB !== 1'b0) begin bad++; $display("FAIL hold_done: got %b want 0", bvalidB); end
  endtask

  task automatic test_wait_states();
    txn_t t;
    bit to;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    set_a(1'b1, 32'h4000_0004, 32'h1234_5678, 4'h1);
    #1;
    total++; if (awreadyA !== 1'b1) begin bad++; $display("FAIL wait_accept: got %b want 1", awreadyA); end
    push_grant(model_grant(1'b1, 1'b0));
    step();
    set_a(1'b0, 32'h0, 32'h0, 4'h0);
    wready = 1'b1;
    #1;
    t = exp_q.pop_front();
    total++; if ({awvalid, wvalid, awaddr} !== {2'b11, t.addr}) begin bad++; $display("FAIL wait_c1: got %b%b/%h want 11/%h", awvalid, wvalid, awaddr, t.addr); end
    step();
    wready = 1'b0;
    #1;
    total++; if ({awvalid, wvalid} !== 2'b10) begin bad++; $display("FAIL wait_c2_wdrop: got %b want 10", {awvalid, wvalid}); end
    step();
    #1;
    total++; if ({awvalid, bready, awaddr} !== {2'b10, t.addr}) begin bad++; $display("FAIL wait_c3_hold: got %b%b/%h want 10/%h", awvalid, bready, awaddr, t.addr); end
    step();
    awready = 1'b1;
    #1;
    total++; if (awvalid !== 1'b1) begin bad++; $display("FAIL wait_c4_awvalid: got %b want 1", awvalid); end
    step();
    #1;
    total++; if ({awvalid, bready} !== 2'b01) begin bad++; $display("FAIL wait_c5_resp: got %b want 01", {awvalid, bready}); end
    finish_resp(RESP_OKAY, to);
    total++; if (to) begin bad++; $display("FAIL wait_resp: got timeout want handshake"); end
    tb_last_b = 1'b0;
  endtask

  task automatic test_reset_in_send();
    txn_t t;
    bit to;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    set_a(1'b1, 32'h5555_0000, 32'h6666_7777, 4'hF);
    #1;
    push_grant(model_grant(1'b1, 1'b0));
    step();
    set_a(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    total++; if (awvalid !== 1'b1) begin bad++; $display("FAIL rsend_in_send: got %b want 1", awvalid); end
    rst_n = 1'b0;
    #1;
    total++; if ({awvalid, wvalid} !== 2'b00) begin bad++; $display("FAIL rsend_async_drop: got %b want 00", {awvalid, wvalid}); end
    total++; if (awaddr !== 32'h0) begin bad++; $display("FAIL rsend_capture_clear: got %h want 0", awaddr); end
    exp_q.delete();
    tb_last_b = 1'b1;
    step();
    rst_n = 1'b1;
    awready = 1'b1; wready = 1'b1;
    step();
    set_a(1'b1, 32'h7000_0008, 32'hCAFE_0001, 4'h8);
    #1;
    total++; if (awreadyA !== 1'b1) begin bad++; $display("FAIL rsend_new_accept: got %b want 1", awreadyA); end
    push_grant(model_grant(1'b1, 1'b0));
    step();
    set_a(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    t = exp_q.pop_front();
    total++; if ({awaddr, wdata, wstrb} !== {t.addr, t.data, t.strb}) begin bad++; $display("FAIL rsend_new_payload: got %h/%h/%h want %h/%h/%h", awaddr, wdata, wstrb, t.addr, t.data, t.strb); end
    finish_resp(RESP_EXOKAY, to);
    total++; if (to) begin bad++; $display("FAIL rsend_new_resp: got timeout want handshake"); end
    tb_last_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    txn_t t;
    bit to;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    set_a(1'b1, 32'hAAAA_0000, 32'h0000_00AA, 4'hA);
    set_b(1'b1, 32'hBBBB_0000, 32'h0000_00BB, 4'h5);
    for (int k = 0; k < 4; k++) begin
      g = model_grant(1'b1, 1'b1);
      #1;
      total++; if ({awreadyB, awreadyA} !== g) begin bad++; $display("FAIL b2b_grant_%0d: got %b want %b", k, {awreadyB, awreadyA}, g); end
      push_grant(g);
      step();
      #1;
      t = exp_q.pop_front();
      total++; if (awaddr !== t.addr) begin bad++; $display("FAIL b2b_addr_%0d: got %h want %h", k, awaddr, t.addr); end
      finish_resp(RESP_OKAY, to);
      total++; if (to) begin bad++; $display("FAIL b2b_resp_%0d: got timeout want handshake", k); end
      tb_last_b = g[1];
    end
    set_a(1'b0, 32'h0, 32'h0, 4'h0);
    set_b(1'b0, 32'h0, 32'h0, 4'h0);
    step();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_priority();
    test_b_partial_slverr();
    test_wait_states();
    test_reset_in_send();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
